// File: rtl/i2s_rx_sample_capture.sv
// I2S receive front-end: synchronises an external I2S stream onto clk,
// deserialises the left-channel word MSB-first and hands it to the notch
// cascade with a one-cycle sample_trig. Samples completing while the cascade
// is still busy are dropped and flagged as overrun.
module i2s_rx_sample_capture #(
  parameter int DATA_SIZE   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lrclk,
  input  logic                 i2s_sdata,
  input  logic                 filter_end,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 sample_trig,
  output logic                 busy,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int               CNT_W    = $clog2(DATA_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_EMIT   = 2'd2,
    ST_WAIT_L = 2'd3
  } state_t;

  // Synchroniser chains; the last stage is the clk-domain view of each pin.
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrclk_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic                   bclk_prev_q;

  logic bclk_s;
  logic lrclk_s;
  logic sdata_s;
  logic bclk_rise;
  logic left_start;

  state_t               state_q,      state_d;
  logic [DATA_SIZE-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0]     bitcnt_q,     bitcnt_d;
  logic [DATA_SIZE-1:0] data_q,       data_d;
  logic                 trig_q,       trig_d;
  logic                 busy_q,       busy_d;
  logic                 overrun_q,    overrun_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 lrclk_prev_q, lrclk_prev_d;

  // Bring the asynchronous I2S pins into the clk domain and keep bclk history
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], i2s_sdata};
      bclk_prev_q  <= bclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign bclk_s     = bclk_sync_q[SYNC_STAGES-1];
  assign lrclk_s    = lrclk_sync_q[SYNC_STAGES-1];
  assign sdata_s    = sdata_sync_q[SYNC_STAGES-1];
  assign bclk_rise  = bclk_s & ~bclk_prev_q;
  // Word select fell between two bit-clock rises: a left slot has begun.
  assign left_start = lrclk_prev_q & ~lrclk_s;

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      data_q       <= '0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      lrclk_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      data_q       <= data_d;
      trig_q       <= trig_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      lrclk_prev_q <= lrclk_prev_d;
    end
  end

  // Next-state, shift/count, hand-off and sticky-flag logic
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    data_d       = data_q;
    trig_d       = 1'b0;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    frame_err_d  = frame_err_q;
    lrclk_prev_d = lrclk_prev_q;

    if (bclk_rise) begin
      lrclk_prev_d = lrclk_s;
    end else begin
      lrclk_prev_d = lrclk_prev_q;
    end

    // A finished filter run frees the cascade; an accepting EMIT re-arms it below.
    if (filter_end) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    case (state_q)
      ST_SYNC, ST_WAIT_L: begin
        // The bit on the left-start edge is the previous right LSB (one-bit delay).
        if (bclk_rise && left_start) begin
          state_d  = ST_SHIFT;
          bitcnt_d = '0;
        end else begin
          state_d = state_q;
        end
      end

      ST_SHIFT: begin
        if (bclk_rise) begin
          // With a slot exactly DATA_SIZE wide, word select already reads
          // right while the LSB is sampled, so only earlier rises are errors.
          if (lrclk_s && (bitcnt_q < LAST_BIT)) begin
            frame_err_d = 1'b1;
            state_d     = ST_SYNC;
            bitcnt_d    = '0;
          end else begin
            shift_d  = {shift_q[DATA_SIZE-2:0], sdata_s};
            bitcnt_d = bitcnt_q + CNT_ONE;
            if (bitcnt_q == LAST_BIT) begin
              state_d = ST_EMIT;
            end else begin
              state_d = ST_SHIFT;
            end
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_EMIT: begin
        // A filter_end in this very cycle makes room for the new sample.
        if (!busy_q || filter_end) begin
          data_d = shift_q;
          trig_d = 1'b1;
          busy_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        bitcnt_d = '0;
        state_d  = ST_WAIT_L;
      end

      default: begin
        state_d  = ST_SYNC;
        bitcnt_d = '0;
      end
    endcase
  end

  assign data_out    = data_q;
  assign sample_trig = trig_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: doc/i2s_rx_sample_capture.md
Name: i2s_rx_sample_capture

Overview:
- Front-end stage that feeds the two-stage notch SOS cascade.
- Receives an external I2S ADC stream on the system clock, deserialises the left-channel word and presents it as a parallel DATA_SIZE sample with a one-cycle sample_trig strobe.
- Tracks the cascade's filter_end to flag samples arriving while the filter is still busy; such samples are dropped.

Parameters:
- DATA_SIZE, 24, sample width in bits; MSB-first, two's complement, matches cascade data_in.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for i2s_bclk, i2s_lrclk and i2s_sdata (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 4x the i2s_bclk frequency.
- reset  input  1  synchronous, active-high reset.
- i2s_bclk  input  1  asynchronous I2S bit clock.
- i2s_lrclk  input  1  asynchronous word select; 0 = left, 1 = right.
- i2s_sdata  input  1  asynchronous serial data; changes on the falling edge of i2s_bclk.
- filter_end  input  1  one-cycle pulse from the cascade marking completion of the current sample.
- data_out  output  DATA_SIZE  last accepted left-channel sample.
- sample_trig  output  1  one-cycle strobe; data_out is valid in the same cycle.
- busy  output  1  high from an issued sample_trig until the matching filter_end.
- overrun  output  1  sticky flag: a complete sample was dropped because busy was high.
- frame_err  output  1  sticky flag: i2s_lrclk rose before DATA_SIZE bits were captured.

Behaviour:
- Reset: on the first clk edge with reset=1, all outputs go to 0, the shift register and bit counter clear, and the FSM enters SYNC.
  - Applies mid-frame: any partial word is discarded.
  - Synchroniser flops also clear to 0.
- Input sampling:
  - All three inputs pass through SYNC_STAGES flops.
  - bclk_rise is a one-cycle pulse when the synchronised bclk goes 0->1.
  - lrclk and sdata are sampled only in cycles where bclk_rise=1.
  - lrclk_prev holds the lrclk value from the previous bclk_rise.
- FSM states, all transitions evaluated only on bclk_rise unless stated:
  - SYNC: wait for lrclk_prev=1 and lrclk=0. Then go to SHIFT with bitcnt=0. The bit sampled on this edge is the previous right-channel LSB and is ignored (standard I2S one-bit delay).
  - SHIFT: shift_reg <= {shift_reg[DATA_SIZE-2:0], sdata}, bitcnt++.
    - If lrclk=1 before bitcnt reaches DATA_SIZE: set frame_err and go to SYNC.
    - When bitcnt reaches DATA_SIZE: go to EMIT on the next clk (not gated by bclk_rise).
  - EMIT: lasts exactly one clk cycle.
    - If busy=0, or filter_end=1 in this same cycle: data_out <= shift_reg, sample_trig=1 in the following cycle, busy=1.
    - Otherwise: set overrun; data_out and busy are unchanged; no trig.
    - Next state is WAIT_L.
  - WAIT_L: ignore the remaining slot bits (e.g. a 32-bit slot) and the whole right channel. Go to SHIFT with bitcnt=0 when lrclk_prev=1 and lrclk=0.
- Latency: sample_trig rises 2 clk cycles after the clk cycle containing the bclk_rise that captured the LSB.
  - data_out changes in the same cycle that sample_trig is high.
  - data_out holds until the next accepted sample.
- busy:
  - Set in the sample_trig cycle.
  - Cleared in the cycle after filter_end.
  - filter_end while busy=0 is ignored.
  - filter_end together with an accepting EMIT leaves busy=1 (clear then set).
- overrun and frame_err: sticky, cleared only by reset; neither stops reception.
- No arithmetic on data: bits are passed through verbatim, and sign is preserved as transmitted.

Test Plan:
- Reset, then one I2S frame with left word 24'h7FFFFF and right word 24'h123456, filter_end returned 10 clk after trig -> exactly one sample_trig, data_out=24'h7FFFFF; busy high for 11 cycles; no flags set.
- Three consecutive frames with left words 24'h800000, 24'h000001, 24'hA5A5A5, each filter_end arriving before the next EMIT -> three trigs, data_out matching in order; overrun=0.
- Second frame completes while filter_end is withheld -> no second trig, data_out stays at the first word, overrun=1. A later filter_end, then a third frame -> trig accepted; overrun remains 1.
- 32-bit slots with left slot 32'hDEADBEEF -> data_out=24'hDEADBE; the trailing 8 bits are ignored; exactly one trig per frame.
- lrclk rises after 10 left bits -> frame_err=1, no trig. The next full frame with 24'h00F00F -> normal trig with data_out=24'h00F00F.
- reset pulsed for 1 cycle after 12 bits of a left word -> all outputs 0 on the next edge, no trig for that word; the next complete left word is captured correctly.
